// File: rtl/line_buffer_bridge_if.sv
// Core-side and physical-memory-side bundles for line_buffer_bridge.
// The core view is a held request / one-cycle mem_resp; the pmem view is 4-beat line bursts.
interface line_buffer_bridge_core_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

interface line_buffer_bridge_pmem_if;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/line_buffer_bridge.sv
// One-line (256-bit) write-back buffer between the RV32I core memory port and 64-bit burst memory.
// Hits answer in one cycle; misses write back a dirty line, then fill the new one in 4 beats.
module line_buffer_bridge (
  input  logic                             clk,
  input  logic                             rst,
  line_buffer_bridge_core_if.slave         core,
  line_buffer_bridge_pmem_if.master        pmem
);

  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

  state_t       r_state;
  logic         r_valid;
  logic         r_dirty;
  logic [26:0]  r_tag;
  logic [26:0]  r_miss_tag;
  logic [255:0] r_line;
  logic [1:0]   r_cnt;
  logic         r_mem_resp;
  logic [31:0]  r_mem_rdata;
  logic         r_pmem_read;
  logic         r_pmem_write;
  logic [31:0]  r_pmem_address;
  logic [63:0]  r_pmem_wdata;

  logic         w_req;
  logic         w_hit;
  logic         w_last_beat;
  logic [7:0]   w_word_base;
  logic [1:0]   w_cnt_next;
  logic [255:0] w_fill_line;
  logic [31:0]  w_hit_word;
  logic [31:0]  w_fill_word;

  assign w_req       = core.mem_read | core.mem_write;
  assign w_hit       = r_valid && (r_tag == core.mem_address[31:5]);
  assign w_word_base = {core.mem_address[4:2], 5'b00000};
  assign w_cnt_next  = r_cnt + 2'd1;
  assign w_last_beat = (r_cnt == 2'd3);
  assign w_hit_word  = r_line[w_word_base +: 32];

  // Line as it will look once the final fill beat lands, so the load word is ready with mem_resp.
  always_comb begin
    w_fill_line          = r_line;
    w_fill_line[255:192] = pmem.pmem_rdata;
  end

  assign w_fill_word = w_fill_line[w_word_base +: 32];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_valid        <= 1'b0;
      r_dirty        <= 1'b0;
      r_cnt          <= 2'd0;
      r_mem_resp     <= 1'b0;
      r_mem_rdata    <= '0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_cnt      <= 2'd0;
            r_miss_tag <= core.mem_address[31:5];
            if (w_hit) begin
              r_state     <= RESP;
              r_mem_resp  <= 1'b1;
              r_mem_rdata <= w_hit_word;
            end else if (r_valid && r_dirty) begin
              r_state        <= WB;
              r_pmem_write   <= 1'b1;
              r_pmem_address <= {r_tag, 5'b00000};
              r_pmem_wdata   <= r_line[63:0];
            end else begin
              r_state        <= FILL;
              r_pmem_read    <= 1'b1;
              r_pmem_address <= {core.mem_address[31:5], 5'b00000};
            end
          end
        end

        WB: begin
          if (pmem.pmem_resp) begin
            r_cnt        <= w_cnt_next;
            r_pmem_wdata <= r_line[{w_cnt_next, 6'b000000} +: 64];
            if (w_last_beat) begin
              // Fill address comes from the tag latched at the miss, since the core may drop its request.
              r_state        <= FILL;
              r_dirty        <= 1'b0;
              r_pmem_write   <= 1'b0;
              r_pmem_read    <= 1'b1;
              r_pmem_address <= {r_miss_tag, 5'b00000};
            end
          end
        end

        FILL: begin
          if (pmem.pmem_resp) begin
            r_line[{r_cnt, 6'b000000} +: 64] <= pmem.pmem_rdata;
            r_cnt <= w_cnt_next;
            if (w_last_beat) begin
              r_pmem_read <= 1'b0;
              r_valid     <= 1'b1;
              r_dirty     <= 1'b0;
              r_tag       <= r_miss_tag;
              if (w_req && (core.mem_address[31:5] == r_miss_tag)) begin
                r_state     <= RESP;
                r_mem_resp  <= 1'b1;
                r_mem_rdata <= w_fill_word;
              end else begin
                r_state <= IDLE;
              end
            end
          end
        end

        RESP: begin
          r_mem_resp <= 1'b0;
          r_state    <= IDLE;
          if (core.mem_write) begin
            for (int i = 0; i < 4; i++) begin
              if (core.mem_byte_enable[i]) begin
                r_line[w_word_base + 8'(8 * i) +: 8] <= core.mem_wdata[8 * i +: 8];
              end
            end
            if (core.mem_byte_enable != 4'd0) begin
              r_dirty <= 1'b1;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign core.mem_resp     = r_mem_resp;
  assign core.mem_rdata    = r_mem_rdata;
  assign pmem.pmem_read    = r_pmem_read;
  assign pmem.pmem_write   = r_pmem_write;
  assign pmem.pmem_address = r_pmem_address;
  assign pmem.pmem_wdata   = r_pmem_wdata;

endmodule

// File: tb/tb_line_buffer_bridge.sv
// Directed self-checking bench for line_buffer_bridge with a burst memory model of configurable stall.
// Expected latencies and data are hand-computed from the bridge's documented behaviour.
module tb_line_buffer_bridge;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  line_buffer_bridge_core_if core ();
  line_buffer_bridge_pmem_if pmem ();

  line_buffer_bridge dut (
    .clk  (clk),
    .rst  (rst),
    .core (core),
    .pmem (pmem)
  );

  int checks = 0;
  int errors = 0;

  int stallCycles = 0;
  int memWait = 0;
  int memBeat = 0;
  int readBeats = 0;
  int writeBeats = 0;
  int streamGlitches = 0;
  logic [31:0]  lastReadAddr = '0;
  logic [31:0]  lastWriteAddr = '0;
  logic [63:0]  firstWbBeat = '0;
  logic [255:0] memLines [0:31];
  logic         prevRead = 1'b0;
  logic         prevWrite = 1'b0;
  logic         prevResp = 1'b0;
  logic [31:0]  prevAddr = '0;
  logic [63:0]  prevWdata = '0;

  // Burst memory: after stallCycles idle cycles, one resp per beat; also watches burst stability.
  always @(negedge clk) begin
    if ((pmem.pmem_read && prevRead) || (pmem.pmem_write && prevWrite)) begin
      if (pmem.pmem_address != prevAddr) streamGlitches++;
    end
    if (pmem.pmem_write && prevWrite && !prevResp && (pmem.pmem_wdata != prevWdata)) streamGlitches++;
    prevRead  = pmem.pmem_read;
    prevWrite = pmem.pmem_write;
    prevAddr  = pmem.pmem_address;
    prevWdata = pmem.pmem_wdata;

    if (pmem.pmem_resp === 1'b1) begin
      memBeat++;
      if (memBeat == 4) memBeat = 0;
    end
    pmem.pmem_resp = 1'b0;
    if (rst) begin
      memBeat = 0;
      memWait = 0;
    end else if (pmem.pmem_read || pmem.pmem_write) begin
      if (memWait < stallCycles) begin
        memWait++;
      end else begin
        memWait = 0;
        pmem.pmem_resp = 1'b1;
        if (pmem.pmem_write) begin
          if (memBeat == 0) begin
            firstWbBeat   = pmem.pmem_wdata;
            lastWriteAddr = pmem.pmem_address;
          end
          memLines[pmem.pmem_address[9:5]][64 * memBeat +: 64] = pmem.pmem_wdata;
          writeBeats++;
        end else begin
          if (memBeat == 0) lastReadAddr = pmem.pmem_address;
          pmem.pmem_rdata = memLines[pmem.pmem_address[9:5]][64 * memBeat +: 64];
          readBeats++;
        end
      end
    end else begin
      memWait = 0;
    end
    prevResp = pmem.pmem_resp;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [3:0] mbe,
                               input logic [31:0] addr, input logic [31:0] wdata);
    core.mem_read        = rd;
    core.mem_write       = wr;
    core.mem_byte_enable = mbe;
    core.mem_address     = addr;
    core.mem_wdata       = wdata;
  endtask

  // Issue one request, count cycles to mem_resp (-1 on timeout), then release it after the RESP edge.
  task automatic access(input logic rd, input logic wr, input logic [3:0] mbe,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int cycles, output logic [31:0] rdata);
    int n;
    n = 0;
    cycles = -1;
    rdata = '0;
    applyStimulus(rd, wr, mbe, addr, wdata);
    while (n < 100 && cycles < 0) begin
      tick();
      n++;
      if (core.mem_resp === 1'b1) begin
        cycles = n;
        rdata = core.mem_rdata;
      end
    end
    tick();
    checkOutput("resp_pulse", 64'(core.mem_resp), 64'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
  endtask

  initial begin
    int cyc;
    int rb;
    int n;
    logic [31:0] rd;

    for (int i = 0; i < 32; i++) begin
      for (int w = 0; w < 8; w++) begin
        memLines[i][32 * w +: 32] = 32'(i * 256 + w);
      end
    end

    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    rst = 1'b1;
    tick();
    tick();
    checkOutput("rst_mem_resp", 64'(core.mem_resp), 64'd0);
    checkOutput("rst_mem_rdata", 64'(core.mem_rdata), 64'd0);
    checkOutput("rst_pmem_read", 64'(pmem.pmem_read), 64'd0);
    checkOutput("rst_pmem_write", 64'(pmem.pmem_write), 64'd0);
    checkOutput("rst_pmem_address", 64'(pmem.pmem_address), 64'd0);
    checkOutput("rst_pmem_wdata", pmem.pmem_wdata, 64'd0);
    rst = 1'b0;
    tick();

    // Clean miss fill of line 0x40000000
    rb = readBeats;
    access(1'b1, 1'b0, 4'd0, 32'h4000_0000, 32'd0, cyc, rd);
    checkOutput("fill_latency", 64'(cyc), 64'd5);
    checkOutput("fill_rdata", 64'(rd), 64'h0);
    checkOutput("fill_beats", 64'(readBeats - rb), 64'd4);
    checkOutput("fill_addr", 64'(lastReadAddr), 64'h4000_0000);
    checkOutput("fill_no_wb", 64'(writeBeats), 64'd0);

    // Read hit on the last word
    rb = readBeats;
    access(1'b1, 1'b0, 4'd0, 32'h4000_001C, 32'd0, cyc, rd);
    checkOutput("hit_latency", 64'(cyc), 64'd1);
    checkOutput("hit_rdata", 64'(rd), 64'h7);
    checkOutput("hit_no_pmem", 64'(readBeats - rb), 64'd0);

    // Partial store then read it back
    access(1'b0, 1'b1, 4'b0101, 32'h4000_0004, 32'hAABB_CCDD, cyc, rd);
    checkOutput("store_latency", 64'(cyc), 64'd1);
    access(1'b1, 1'b0, 4'd0, 32'h4000_0004, 32'd0, cyc, rd);
    checkOutput("store_merge", 64'(rd), 64'h00BB_00DD);

    // Dirty miss: write-back then fill
    rb = readBeats;
    access(1'b1, 1'b0, 4'd0, 32'h4000_0020, 32'd0, cyc, rd);
    checkOutput("dirty_latency", 64'(cyc), 64'd9);
    checkOutput("dirty_rdata", 64'(rd), 64'h100);
    checkOutput("wb_beats", 64'(writeBeats), 64'd4);
    checkOutput("wb_addr", 64'(lastWriteAddr), 64'h4000_0000);
    checkOutput("wb_beat0", firstWbBeat, 64'h00BB_00DD_0000_0000);
    checkOutput("wb_mem_word1", 64'(memLines[0][63:32]), 64'h00BB_00DD);
    checkOutput("dirty_fill_addr", 64'(lastReadAddr), 64'h4000_0020);
    checkOutput("dirty_fill_beats", 64'(readBeats - rb), 64'd4);

    // Second miss is clean: no write-back
    access(1'b1, 1'b0, 4'd0, 32'h4000_0000, 32'd0, cyc, rd);
    checkOutput("clean_latency", 64'(cyc), 64'd5);
    checkOutput("clean_rdata", 64'(rd), 64'h0);
    checkOutput("clean_no_wb", 64'(writeBeats), 64'd4);

    // Stalled memory: 3 idle cycles before each beat
    stallCycles = 3;
    access(1'b1, 1'b0, 4'd0, 32'h4000_0024, 32'd0, cyc, rd);
    checkOutput("stall_latency", 64'(cyc), 64'd17);
    checkOutput("stall_rdata", 64'(rd), 64'h101);
    checkOutput("stall_stable", 64'(streamGlitches), 64'd0);

    // Reset after two beats of a stalled fill
    rb = readBeats;
    applyStimulus(1'b1, 1'b0, 4'd0, 32'h4000_0008, 32'd0);
    n = 0;
    while (n < 100 && (readBeats - rb) < 2) begin
      tick();
      n++;
    end
    checkOutput("mid_beats", 64'(readBeats - rb), 64'd2);
    checkOutput("mid_read_high", 64'(pmem.pmem_read), 64'd1);
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_read", 64'(pmem.pmem_read), 64'd0);
    checkOutput("mid_rst_write", 64'(pmem.pmem_write), 64'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    rst = 1'b0;
    stallCycles = 0;
    tick();

    rb = readBeats;
    access(1'b1, 1'b0, 4'd0, 32'h4000_0020, 32'd0, cyc, rd);
    checkOutput("refill_latency", 64'(cyc), 64'd5);
    checkOutput("refill_rdata", 64'(rd), 64'h100);
    checkOutput("refill_beats", 64'(readBeats - rb), 64'd4);

    // Store with no byte lanes on a hit: line and dirty flag untouched
    access(1'b0, 1'b1, 4'd0, 32'h4000_0028, 32'hFFFF_FFFF, cyc, rd);
    checkOutput("mbe0_latency", 64'(cyc), 64'd1);
    access(1'b1, 1'b0, 4'd0, 32'h4000_0028, 32'd0, cyc, rd);
    checkOutput("mbe0_unchanged", 64'(rd), 64'h102);
    access(1'b1, 1'b0, 4'd0, 32'h4000_0000, 32'd0, cyc, rd);
    checkOutput("mbe0_miss_latency", 64'(cyc), 64'd5);
    checkOutput("mbe0_no_wb", 64'(writeBeats), 64'd4);
    checkOutput("final_stable", 64'(streamGlitches), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
